// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its controller.
package instr_register_pkg;

    localparam int unsigned DEPTH = 32;

    typedef enum logic [3:0] {
        ZERO,
        PASSA,
        PASSB,
        ADD,
        SUB,
        MULT,
        DIV,
        MOD
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic [4:0]         address_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_FULL
    } ctrl_state_t;

    // Circular pointer advance, wrapping at the last entry.
    function automatic address_t ptr_inc(input address_t p, input int unsigned depth);
        return (32'(p) == depth - 1) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/instr_rr_arbiter.sv
// Two-requester round-robin arbiter; last_grant remembers the previous winner.
module instr_rr_arbiter (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    logic last_grant;

    // Grant the lone requester, or the one that did not win last time.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (enable) begin
            if (req0 && (!req1 || last_grant))
                gnt0 = 1'b1;
            else if (req1)
                gnt1 = 1'b1;
        end
    end

    // Track the most recent winner; starting at 1 lets requester 0 win first.
    always_ff @(posedge clk) begin
        if (reset)
            last_grant <= 1'b1;
        else if (gnt0)
            last_grant <= 1'b0;
        else if (gnt1)
            last_grant <= 1'b1;
    end

endmodule

// File: rtl/instr_reg_ctrl.sv
// Runs the instruction register as a circular FIFO fed by two arbitrated writers.
module instr_reg_ctrl
    import instr_register_pkg::*;
#(
    parameter int unsigned DEPTH = instr_register_pkg::DEPTH,
    parameter int          CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic             req1_valid,
    input  opcode_t          req0_opcode,
    input  opcode_t          req1_opcode,
    input  operand_t         req0_op_a,
    input  operand_t         req0_op_b,
    input  operand_t         req1_op_a,
    input  operand_t         req1_op_b,
    output logic             gnt0,
    output logic             gnt1,
    input  logic             rd_req,
    output logic             rd_ack,
    output logic             rd_valid,
    output instruction_t     rd_data,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             load_en,
    output opcode_t          opcode,
    output operand_t         operand_a,
    output operand_t         operand_b,
    output address_t         write_pointer,
    output address_t         read_pointer,
    output logic             reg_reset_n,
    input  instruction_t     instruction_word
);

    ctrl_state_t      state, state_next;
    address_t         wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count_next;
    logic             arb_en;
    logic             wr_grant;

    // A write still in flight (load_en high) already reserves its slot.
    assign full        = ({1'b0, count} + {{CNT_W{1'b0}}, load_en}) == (CNT_W+1)'(DEPTH);
    assign empty       = (state == S_IDLE);
    assign arb_en      = ~full & ~flush & ~reset;
    assign rd_ack      = rd_req & ~empty & ~flush & ~reset;
    assign read_pointer = rd_ptr;
    assign reg_reset_n = ~reset;
    assign wr_grant    = gnt0 | gnt1;

    instr_rr_arbiter u_arb (
        .clk    (clk),
        .reset  (reset),
        .enable (arb_en),
        .req0   (req0_valid),
        .req1   (req1_valid),
        .gnt0   (gnt0),
        .gnt1   (gnt1)
    );

    // Occupancy follows commits (load_en cycle) and pops; state follows occupancy.
    always_comb begin
        count_next = count;
        state_next = state;
        if (flush) begin
            count_next = '0;
        end else begin
            case ({load_en, rd_ack})
                2'b10:   count_next = count + 1'b1;
                2'b01:   count_next = count - 1'b1;
                default: count_next = count;
            endcase
        end
        if (flush || count_next == '0)
            state_next = S_IDLE;
        else if (count_next == CNT_W'(DEPTH))
            state_next = S_FULL;
        else
            state_next = S_ACTIVE;
    end

    // State, occupancy and FIFO pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_grant)
                    wr_ptr <= ptr_inc(wr_ptr, DEPTH);
                if (rd_ack)
                    rd_ptr <= ptr_inc(rd_ptr, DEPTH);
            end
        end
    end

    // Register write port: the granted requester's word lands one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            load_en       <= 1'b0;
            opcode        <= ZERO;
            operand_a     <= '0;
            operand_b     <= '0;
            write_pointer <= '0;
        end else begin
            load_en <= wr_grant;
            if (gnt0) begin
                opcode        <= req0_opcode;
                operand_a     <= req0_op_a;
                operand_b     <= req0_op_b;
                write_pointer <= wr_ptr;
            end else if (gnt1) begin
                opcode        <= req1_opcode;
                operand_a     <= req1_op_a;
                operand_b     <= req1_op_b;
                write_pointer <= wr_ptr;
            end
        end
    end

    // Read side: capture the oldest entry on an accepted pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_ack;
            if (rd_ack)
                rd_data <= instruction_word;
        end
    end

endmodule

// File: tb/tb_instr_reg_ctrl.sv
// Randomized scoreboard bench for instr_reg_ctrl with a queue-based FIFO model.
module tb_instr_reg_ctrl;
    import instr_register_pkg::*;

    logic         clk = 1'b0;
    logic         reset, flush, rd_req;
    logic         req0_valid, req1_valid;
    opcode_t      req0_opcode, req1_opcode;
    operand_t     req0_op_a, req0_op_b, req1_op_a, req1_op_b;
    logic         gnt0, gnt1, rd_ack, rd_valid;
    instruction_t rd_data;
    logic [5:0]   count;
    logic         full, empty, load_en, reg_reset_n;
    opcode_t      opcode;
    operand_t     operand_a, operand_b;
    address_t     write_pointer, read_pointer;
    instruction_t instruction_word;

    instr_reg_ctrl #(.DEPTH(32), .CNT_W(6)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_opcode(req0_opcode), .req1_opcode(req1_opcode),
        .req0_op_a(req0_op_a), .req0_op_b(req0_op_b),
        .req1_op_a(req1_op_a), .req1_op_b(req1_op_b),
        .gnt0(gnt0), .gnt1(gnt1),
        .rd_req(rd_req), .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
        .flush(flush), .count(count), .full(full), .empty(empty),
        .load_en(load_en), .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
        .write_pointer(write_pointer), .read_pointer(read_pointer),
        .reg_reset_n(reg_reset_n), .instruction_word(instruction_word)
    );

    always #5 clk = ~clk;

    // Behavioural instruction register: written on load_en, read combinationally.
    instruction_t mem [32];
    assign instruction_word = mem[read_pointer];
    always @(posedge clk)
        if (load_en === 1'b1 && reg_reset_n === 1'b1)
            mem[write_pointer] <= {opcode, operand_a, operand_b};

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endfunction

    // Reference model: committed entries, one in-flight write, pointers as counters.
    typedef struct { int due; instruction_t ins; int wp; } ld_t;
    typedef struct { int due; instruction_t ins; } rd_t;
    ld_t          ld_q[$];
    rd_t          rd_q[$];
    instruction_t vis_q[$];
    bit           pend_v = 0;
    instruction_t pend_i;
    int           wp_m = 0, rp_m = 0, last_m = 1;
    bit           rst_chk = 0;
    bit           mon_on = 0;

    // Monitor: every registered load/read must match the head of its queue.
    always @(negedge clk) begin
        bit ld_due, rd_due;
        if (mon_on) begin
            ld_due = (ld_q.size() > 0) && (ld_q[0].due == cyc);
            chk("load_en", 64'(load_en), 64'(ld_due));
            if (ld_due) begin
                if (load_en === 1'b1) begin
                    chk("load opcode", 64'(opcode), 64'(ld_q[0].ins.opc));
                    chk("load operand_a", 64'(operand_a), 64'(ld_q[0].ins.op_a));
                    chk("load operand_b", 64'(operand_b), 64'(ld_q[0].ins.op_b));
                    chk("write_pointer", 64'(write_pointer), 64'(ld_q[0].wp));
                end
                void'(ld_q.pop_front());
            end
            rd_due = (rd_q.size() > 0) && (rd_q[0].due == cyc);
            chk("rd_valid", 64'(rd_valid), 64'(rd_due));
            if (rd_due) begin
                if (rd_valid === 1'b1) begin
                    chk("rd_data.opc", 64'(rd_data.opc), 64'(rd_q[0].ins.opc));
                    chk("rd_data.op_a", 64'(rd_data.op_a), 64'(rd_q[0].ins.op_a));
                    chk("rd_data.op_b", 64'(rd_data.op_b), 64'(rd_q[0].ins.op_b));
                end
                void'(rd_q.pop_front());
            end
        end
    end

    function automatic instruction_t mk(input opcode_t o, input int a, input int b);
        instruction_t i;
        i.opc  = o;
        i.op_a = a;
        i.op_b = b;
        return i;
    endfunction

    function automatic instruction_t rnd_instr();
        return mk(opcode_t'($urandom_range(0, 7)), int'($urandom), int'($urandom));
    endfunction

    // One clock of stimulus: drive, check combinational outputs, advance the model.
    task automatic cycle(input bit rst, input bit fl, input bit v0, input bit v1, input bit rr,
                         input instruction_t i0, input instruction_t i1);
        bit e_full, e_empty, e_g0, e_g1, e_ack;
        @(negedge clk);
        reset = rst; flush = fl; rd_req = rr;
        req0_valid = v0; req1_valid = v1;
        req0_opcode = i0.opc; req0_op_a = i0.op_a; req0_op_b = i0.op_b;
        req1_opcode = i1.opc; req1_op_a = i1.op_a; req1_op_b = i1.op_b;
        #2;
        e_empty = (vis_q.size() == 0);
        e_full  = (vis_q.size() + int'(pend_v)) == 32;
        e_g0 = 0; e_g1 = 0;
        if (!rst && !fl && !e_full) begin
            if (v0 && v1) begin
                if (last_m == 1) e_g0 = 1; else e_g1 = 1;
            end else begin
                e_g0 = v0; e_g1 = v1;
            end
        end
        e_ack = rr && !e_empty && !fl && !rst;
        chk("count", 64'(count), 64'(vis_q.size()));
        chk("full", 64'(full), 64'(e_full));
        chk("empty", 64'(empty), 64'(e_empty));
        chk("read_pointer", 64'(read_pointer), 64'(rp_m));
        chk("gnt0", 64'(gnt0), 64'(e_g0));
        chk("gnt1", 64'(gnt1), 64'(e_g1));
        chk("rd_ack", 64'(rd_ack), 64'(e_ack));
        chk("reg_reset_n", 64'(reg_reset_n), 64'(!rst));
        if (rst_chk) begin
            chk("reset opcode", 64'(opcode), 64'(ZERO));
            chk("reset operand_a", 64'(operand_a), 64'd0);
            chk("reset operand_b", 64'(operand_b), 64'd0);
            chk("reset write_pointer", 64'(write_pointer), 64'd0);
            chk("reset rd_data", 64'(rd_data), 64'd0);
            rst_chk = 0;
        end
        if (rst) begin
            vis_q.delete(); pend_v = 0; wp_m = 0; rp_m = 0; last_m = 1; rst_chk = 1;
        end else if (fl) begin
            vis_q.delete(); pend_v = 0; wp_m = 0; rp_m = 0;
        end else begin
            if (e_ack) begin
                rd_q.push_back('{cyc + 1, vis_q.pop_front()});
                rp_m = (rp_m + 1) % 32;
            end
            if (pend_v) vis_q.push_back(pend_i);
            pend_v = 0;
            if (e_g0 || e_g1) begin
                pend_i = e_g0 ? i0 : i1;
                pend_v = 1;
                ld_q.push_back('{cyc + 1, pend_i, wp_m});
                wp_m   = (wp_m + 1) % 32;
                last_m = e_g0 ? 0 : 1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, '0, '0);
    endtask

    initial begin
        int p_w, p_r;
        reset = 1; flush = 0; rd_req = 0; req0_valid = 0; req1_valid = 0;
        req0_opcode = ZERO; req1_opcode = ZERO;
        req0_op_a = '0; req0_op_b = '0; req1_op_a = '0; req1_op_b = '0;
        for (int k = 0; k < 32; k++) mem[k] = '0;
        repeat (2) @(posedge clk);
        mon_on = 1;

        cycle(1, 0, 0, 0, 0, '0, '0);
        // Single requester writes ADD 5,3.
        cycle(0, 0, 1, 0, 0, mk(ADD, 5, 3), '0);
        idle(3);
        // Both requesters for four cycles: alternating grants.
        for (int k = 0; k < 4; k++) cycle(0, 0, 1, 1, 0, rnd_instr(), rnd_instr());
        // Fill to full and keep requesting, then pop once while both still request.
        for (int k = 0; k < 34; k++) cycle(0, 0, 1, 1, 0, rnd_instr(), rnd_instr());
        cycle(0, 0, 1, 1, 1, rnd_instr(), rnd_instr());
        for (int k = 0; k < 4; k++) cycle(0, 0, 1, 1, 0, rnd_instr(), rnd_instr());
        // Drain beyond empty.
        for (int k = 0; k < 36; k++) cycle(0, 0, 0, 0, 1, '0, '0);
        // Pop from empty, then MULT 2,7 written and popped.
        cycle(0, 0, 0, 0, 1, '0, '0);
        cycle(0, 0, 0, 1, 0, '0, mk(MULT, 2, 7));
        idle(2);
        cycle(0, 0, 0, 0, 1, '0, '0);
        idle(2);
        // Reset on the grant cycle, and reset on the load_en cycle.
        cycle(1, 0, 1, 0, 0, rnd_instr(), '0);
        cycle(0, 0, 1, 0, 0, rnd_instr(), '0);
        cycle(1, 0, 1, 1, 1, rnd_instr(), rnd_instr());
        idle(2);
        // Build to ten entries, commit and pop together, then flush and write.
        for (int k = 0; k < 10; k++) cycle(0, 0, 1, 0, 0, rnd_instr(), '0);
        idle(1);
        cycle(0, 0, 1, 0, 0, rnd_instr(), '0);
        cycle(0, 0, 0, 0, 1, '0, '0);
        cycle(0, 0, 1, 1, 0, rnd_instr(), rnd_instr());
        cycle(0, 1, 1, 1, 1, rnd_instr(), rnd_instr());
        cycle(0, 0, 1, 0, 0, rnd_instr(), '0);
        idle(2);
        // Randomized phases with shifting write/read pressure.
        for (int ph = 0; ph < 12; ph++) begin
            p_w = $urandom_range(10, 90);
            p_r = $urandom_range(10, 90);
            for (int k = 0; k < 150; k++)
                cycle($urandom_range(0, 199) == 0, $urandom_range(0, 99) == 0,
                      $urandom_range(0, 99) < p_w, $urandom_range(0, 99) < p_w,
                      $urandom_range(0, 99) < p_r, rnd_instr(), rnd_instr());
        end
        for (int k = 0; k < 40; k++) cycle(0, 0, 0, 0, 1, '0, '0);
        idle(2);
        chk("load queue drained", 64'(ld_q.size()), 64'd0);
        chk("read queue drained", 64'(rd_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
